alu_exec_seq: RTL



---
 rtl/alu_exec_seq.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_seq.sv
// -----------------------------------------------------------------------------
// alu_exec_seq
//   Execute-stage sequencer owning the 32-bit ALU datapath. One decoded RV32I
//   instruction is accepted per IN_VALID/IN_READY handshake; operands are
//   selected and latched at accept, the result is computed and returned with
//   its destination register through an OUT_VALID/OUT_READY handshake.
//
//   Optional feature macro: ALU_FAST_SHIFT_EN
//     defined   -> shifts use a single-cycle barrel shifter in EXEC
//     undefined -> shifts run 1 bit per cycle in the SHIFT state
//
// Ports
//   CLK, RST_N         clock (rising edge), async active-low reset
//   IN_VALID/IN_READY  instruction handshake (ready only in IDLE, not flushing)
//   OPCODE, FUNCT3, FUNCT7_B5, RD          decoded instruction fields
//   RS1_DATA, RS2_DATA, PC, IMM12, U_IMM20 operand sources
//   FLUSH              synchronous discard of the in-flight instruction
//   OUT_VALID/OUT_READY result handshake
//   OUT_RESULT, OUT_RD, OUT_ILLEGAL        result, destination, bad-opcode flag
//   BUSY               sequencer is not IDLE
// -----------------------------------------------------------------------------
module alu_exec_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic        FUNCT7_B5,
  input  logic [4:0]  RD,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] PC,
  input  logic [11:0] IMM12,
  input  logic [19:0] U_IMM20,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RESULT,
  output logic [4:0]  OUT_RD,
  output logic        OUT_ILLEGAL,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_XOR  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } op_e;

  // FUNCT3 -> ALU op. SUB only exists for register-register ops; the SRA/SRL
  // choice applies to both immediate and register shifts.
  function automatic op_e f3_op(input logic [2:0] f3, input logic b5, input logic is_reg);
    op_e op;
    case (f3)
      3'b000:  op = (is_reg && b5) ? OP_SUB : OP_ADD;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      3'b001:  op = OP_SLL;
      3'b101:  op = b5 ? OP_SRA : OP_SRL;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  op_e         op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_illegal_q, out_illegal_d;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  op_e         dec_op;
  logic        dec_illegal;
  logic        dec_shift;
  logic [31:0] imm_sext;
  logic [31:0] u_imm;
  logic [31:0] alu_res;
  logic [31:0] shift_step;

  // Operand selection and op decode for the instruction currently presented.
  always_comb begin
    imm_sext    = {{20{IMM12[11]}}, IMM12};
    u_imm       = {U_IMM20, 12'd0};
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (OPCODE)
      7'b0010011: begin
        dec_a  = RS1_DATA;
        dec_b  = imm_sext;
        dec_op = f3_op(FUNCT3, FUNCT7_B5, 1'b0);
      end
      7'b0110011: begin
        dec_a  = RS1_DATA;
        dec_b  = RS2_DATA;
        dec_op = f3_op(FUNCT3, FUNCT7_B5, 1'b1);
      end
      7'b0000011, 7'b0100011: begin
        // load/store address generation
        dec_a = RS1_DATA;
        dec_b = imm_sext;
      end
      7'b0110111: begin
        dec_b = u_imm;
      end
      7'b0010111: begin
        dec_a = PC;
        dec_b = u_imm;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    dec_shift = !dec_illegal &&
                ((dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA));
  end

  // Single-cycle ALU on the latched operands.
  always_comb begin
    alu_res = 32'd0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {31'd0, (a_q < b_q)};
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = a_q << b_q[4:0];
      OP_SRL:  alu_res = a_q >> b_q[4:0];
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[4:0]);
`endif
      default: alu_res = 32'd0;
    endcase
  end

  // One-bit step of the iterative shifter; the accumulator lives in a_q.
  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = {a_q[30:0], 1'b0};
      OP_SRA:  shift_step = {a_q[31], a_q[31:1]};
      default: shift_step = {1'b0, a_q[31:1]};
    endcase
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (FLUSH) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            a_d       = dec_a;
            b_d       = dec_b;
            op_d      = dec_op;
            rd_d      = RD;
            illegal_d = dec_illegal;
`ifdef ALU_FAST_SHIFT_EN
            state_d   = ST_EXEC;
`else
            if (dec_shift) begin
              state_d = ST_SHIFT;
              cnt_d   = dec_b[4:0];
            end else begin
              state_d = ST_EXEC;
            end
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXEC: begin
          out_result_d  = illegal_q ? 32'd0 : alu_res;
          out_illegal_d = illegal_q;
          out_rd_d      = rd_q;
          out_valid_d   = 1'b1;
          state_d       = ST_DONE;
        end
        ST_SHIFT: begin
          if (cnt_q != 5'd0) begin
            a_d   = shift_step;
            cnt_d = cnt_q - 5'd1;
          end else begin
            out_result_d  = a_q;
            out_illegal_d = 1'b0;
            out_rd_d      = rd_q;
            out_valid_d   = 1'b1;
            state_d       = ST_DONE;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= OP_ADD;
      rd_q          <= 5'd0;
      illegal_q     <= 1'b0;
      cnt_q         <= 5'd0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'd0;
      out_rd_q      <= 5'd0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      illegal_q     <= illegal_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  // IN_READY must drop in the same cycle FLUSH is raised, so it is gated here.
  assign IN_READY    = (state_q == ST_IDLE) && !FLUSH;
  assign BUSY        = (state_q != ST_IDLE);
  assign OUT_VALID   = out_valid_q;
  assign OUT_RESULT  = out_result_q;
  assign OUT_RD      = out_rd_q;
  assign OUT_ILLEGAL = out_illegal_q;

endmodule
